param_cache_bank: RTL and testbench

Parametrised, blocking, write-back, write-allocate cache bank with configurable associativity, set count and block size. It replaces fixed per-level cache configurations with one RTL block instantiated per level (L1/L2/L3). Adds true-LRU replacement, a victim write-back FSM, and a whole-cache flush. It sits between a processor-side word request port and a block-wide lower-level memory port.

---
 rtl/cache_bank_pkg.sv | 20 ++
 rtl/param_cache_bank_if.sv | 39 +++
 rtl/cache_lru_tracker.sv | 53 +++++
 rtl/param_cache_bank.sv | 247 ++++++++++++++++++++++++
 tb/tb_param_cache_bank.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_bank_pkg.sv
// Shared types and width helpers for the parametrised cache bank.
package cache_bank_pkg;

  localparam int BYTE_OFF_WIDTH = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WRITEBACK,
    ST_REFILL,
    ST_RESPOND,
    ST_FLUSH
  } state_t;

  // Index width for a power-of-two count; a single entry still needs one bit.
  function automatic int field_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/param_cache_bank_if.sv
// Processor-side request/response and lower-level block port of one cache bank.
interface param_cache_bank_if #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int WORDS_PER_BLOCK = 4
);
  logic                                  req_valid;
  logic                                  req_ready;
  logic                                  req_write;
  logic [ADDRESS_WIDTH-1:0]              req_addr;
  logic [DATA_WIDTH-1:0]                 req_wdata;
  logic                                  resp_valid;
  logic                                  resp_hit;
  logic [DATA_WIDTH-1:0]                 resp_rdata;
  logic                                  flush_req;
  logic                                  flush_done;
  logic                                  mem_req_valid;
  logic                                  mem_req_ready;
  logic                                  mem_req_write;
  logic [ADDRESS_WIDTH-1:0]              mem_req_addr;
  logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] mem_wdata;
  logic                                  mem_resp_valid;
  logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] mem_rdata;

  // master: processor plus lower-level memory; slave: the cache bank.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, flush_req,
           mem_req_ready, mem_resp_valid, mem_rdata,
    input  req_ready, resp_valid, resp_hit, resp_rdata, flush_done,
           mem_req_valid, mem_req_write, mem_req_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, flush_req,
           mem_req_ready, mem_resp_valid, mem_rdata,
    output req_ready, resp_valid, resp_hit, resp_rdata, flush_done,
           mem_req_valid, mem_req_write, mem_req_addr, mem_wdata
  );
endinterface

// File: rtl/cache_lru_tracker.sv
// True-LRU age tracker: one age per way per set, identity ages out of reset.
module cache_lru_tracker
  import cache_bank_pkg::*;
#(
  parameter  int NUM_WAYS    = 4,
  parameter  int NUM_SETS    = 4,
  localparam int INDEX_WIDTH = field_width(NUM_SETS),
  localparam int AGE_WIDTH   = field_width(NUM_WAYS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INDEX_WIDTH-1:0] lookup_set,
  output logic [AGE_WIDTH-1:0]   lru_way,
  input  logic                   upd_en,
  input  logic [INDEX_WIDTH-1:0] upd_set,
  input  logic [AGE_WIDTH-1:0]   upd_way
);

  if (NUM_WAYS == 1) begin : g_direct
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst_n, lookup_set, upd_en, upd_set, upd_way};
    assign lru_way       = '0;
  end else begin : g_assoc
    logic [AGE_WIDTH-1:0] age [NUM_SETS][NUM_WAYS];

    // NOTE: this array is reset because victim choice depends on it being a
    // permutation; bulk line data elsewhere is deliberately left unreset.
    // NOTE: state is always written with <= so every reader sees pre-edge ages.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int s = 0; s < NUM_SETS; s++)
          for (int w = 0; w < NUM_WAYS; w++)
            age[s][w] <= AGE_WIDTH'(w);
      end else if (upd_en) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (AGE_WIDTH'(w) == upd_way)
            age[upd_set][w] <= '0;
          else if (age[upd_set][w] < age[upd_set][upd_way])
            age[upd_set][w] <= age[upd_set][w] + 1'b1;
        end
      end
    end

    // NOTE: default first so no path through the loop can infer a latch.
    always_comb begin
      lru_way = '0;
      for (int w = 0; w < NUM_WAYS; w++)
        if (age[lookup_set][w] == AGE_WIDTH'(NUM_WAYS - 1))
          lru_way = AGE_WIDTH'(w);
    end
  end

endmodule

// File: rtl/param_cache_bank.sv
// Blocking write-back, write-allocate cache bank with true-LRU replacement,
// victim write-back and whole-cache flush.
module param_cache_bank
  import cache_bank_pkg::*;
#(
  parameter int NUM_WAYS        = 4,
  parameter int NUM_SETS        = 4,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int PROC_ID_WIDTH   = 2
) (
  input logic               clk,
  input logic               rst_n,
  param_cache_bank_if.slave bus
);

  localparam int INDEX_WIDTH    = field_width(NUM_SETS);
  localparam int WORD_OFF_WIDTH = field_width(WORDS_PER_BLOCK);
  localparam int WAY_WIDTH      = field_width(NUM_WAYS);
  localparam int INDEX_LSB      = BYTE_OFF_WIDTH + WORD_OFF_WIDTH;
  localparam int TAG_LSB        = INDEX_LSB + INDEX_WIDTH;
  localparam int TAG_WIDTH      = ADDRESS_WIDTH - PROC_ID_WIDTH - TAG_LSB;
  localparam int BLOCK_BITS     = DATA_WIDTH * WORDS_PER_BLOCK;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_WIDTH-1:0] tag;
  } line_meta_t;

  state_t state, state_nxt;

  line_meta_t            meta     [NUM_SETS][NUM_WAYS];
  logic [BLOCK_BITS-1:0] data_mem [NUM_SETS][NUM_WAYS];

  logic                      req_write_q;
  logic [TAG_WIDTH-1:0]      req_tag_q;
  logic [INDEX_WIDTH-1:0]    req_idx_q;
  logic [WORD_OFF_WIDTH-1:0] req_woff_q;
  logic [DATA_WIDTH-1:0]     req_wdata_q;
  logic [WAY_WIDTH-1:0]      victim_q;
  logic                      refill_sent_q;
  logic                      flush_done_q;
  logic [INDEX_WIDTH-1:0]    flush_set;
  logic [WAY_WIDTH-1:0]      flush_way;

  logic                  hit, inv_found;
  logic [WAY_WIDTH-1:0]  hit_way, inv_way, lru_way, victim_way, lru_upd_way;
  logic                  accept, lru_upd, store_hit, install, refill_issue;
  logic                  flush_clear, flush_last;
  logic [BLOCK_BITS-1:0] refill_block;
  line_meta_t            lookup_victim, victim_meta, flush_meta;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.req_addr[ADDRESS_WIDTH-1 -: PROC_ID_WIDTH],
                              bus.req_addr[BYTE_OFF_WIDTH-1:0]};

  function automatic logic [ADDRESS_WIDTH-1:0] block_addr(
    input logic [TAG_WIDTH-1:0]   tag,
    input logic [INDEX_WIDTH-1:0] idx
  );
    block_addr                           = '0;
    block_addr[TAG_LSB +: TAG_WIDTH]     = tag;
    block_addr[INDEX_LSB +: INDEX_WIDTH] = idx;
  endfunction

  // Tag match, plus lowest-index invalid way as the preferred victim.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (meta[req_idx_q][w].valid && meta[req_idx_q][w].tag == req_tag_q) begin
        hit     = 1'b1;
        hit_way = WAY_WIDTH'(w);
      end
      if (!meta[req_idx_q][w].valid) begin
        inv_found = 1'b1;
        inv_way   = WAY_WIDTH'(w);
      end
    end
  end

  assign victim_way    = inv_found ? inv_way : lru_way;
  assign lookup_victim = meta[req_idx_q][victim_way];
  assign victim_meta   = meta[req_idx_q][victim_q];
  assign flush_meta    = meta[flush_set][flush_way];
  assign flush_last    = (flush_set == INDEX_WIDTH'(NUM_SETS - 1)) &&
                         (flush_way == WAY_WIDTH'(NUM_WAYS - 1));

  always_comb begin
    refill_block = bus.mem_rdata;
    if (req_write_q)
      refill_block[int'(req_woff_q)*DATA_WIDTH +: DATA_WIDTH] = req_wdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    bus.req_ready     = 1'b0;
    bus.resp_valid    = 1'b0;
    bus.resp_hit      = 1'b0;
    bus.resp_rdata    = '0;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_write = 1'b0;
    bus.mem_req_addr  = '0;
    bus.mem_wdata     = '0;
    accept            = 1'b0;
    lru_upd           = 1'b0;
    lru_upd_way       = hit_way;
    store_hit         = 1'b0;
    install           = 1'b0;
    refill_issue      = 1'b0;
    flush_clear       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.flush_req) begin
          state_nxt = ST_FLUSH;
        end else if (bus.req_valid) begin
          accept    = 1'b1;
          state_nxt = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          bus.resp_valid = 1'b1;
          bus.resp_hit   = 1'b1;
          bus.resp_rdata = req_write_q ? req_wdata_q :
                           data_mem[req_idx_q][hit_way][int'(req_woff_q)*DATA_WIDTH +: DATA_WIDTH];
          store_hit      = req_write_q;
          lru_upd        = 1'b1;
          state_nxt      = ST_IDLE;
        end else if (lookup_victim.valid && lookup_victim.dirty) begin
          state_nxt = ST_WRITEBACK;
        end else begin
          state_nxt = ST_REFILL;
        end
      end
      ST_WRITEBACK: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_write = 1'b1;
        bus.mem_req_addr  = block_addr(victim_meta.tag, req_idx_q);
        bus.mem_wdata     = data_mem[req_idx_q][victim_q];
        if (bus.mem_req_ready) state_nxt = ST_REFILL;
      end
      ST_REFILL: begin
        bus.mem_req_valid = !refill_sent_q;
        bus.mem_req_addr  = block_addr(req_tag_q, req_idx_q);
        refill_issue      = !refill_sent_q && bus.mem_req_ready;
        // The refill may return in the very cycle the read is accepted.
        if ((refill_sent_q || refill_issue) && bus.mem_resp_valid) begin
          install   = 1'b1;
          state_nxt = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = data_mem[req_idx_q][victim_q][int'(req_woff_q)*DATA_WIDTH +: DATA_WIDTH];
        lru_upd        = 1'b1;
        lru_upd_way    = victim_q;
        state_nxt      = ST_IDLE;
      end
      ST_FLUSH: begin
        if (flush_meta.valid && flush_meta.dirty) begin
          bus.mem_req_valid = 1'b1;
          bus.mem_req_write = 1'b1;
          bus.mem_req_addr  = block_addr(flush_meta.tag, flush_set);
          bus.mem_wdata     = data_mem[flush_set][flush_way];
          flush_clear       = bus.mem_req_ready;
        end else begin
          flush_clear = 1'b1;
        end
        if (flush_clear && flush_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    bus.flush_done = flush_done_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refill_sent_q <= 1'b0;
      flush_done_q  <= 1'b0;
      flush_set     <= '0;
      flush_way     <= '0;
      victim_q      <= '0;
    end else begin
      flush_done_q  <= flush_clear && flush_last;
      refill_sent_q <= (state == ST_REFILL) && !install && (refill_sent_q || refill_issue);
      if (state == ST_LOOKUP) victim_q <= victim_way;
      if (flush_clear) begin
        flush_way <= (flush_way == WAY_WIDTH'(NUM_WAYS - 1)) ? '0 : flush_way + 1'b1;
        if (flush_way == WAY_WIDTH'(NUM_WAYS - 1)) flush_set <= flush_set + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++) begin
          meta[s][w].valid <= 1'b0;
          meta[s][w].dirty <= 1'b0;
        end
    end else begin
      if (store_hit) meta[req_idx_q][hit_way].dirty <= 1'b1;
      if (install)   meta[req_idx_q][victim_q] <= '{valid: 1'b1, dirty: req_write_q, tag: req_tag_q};
      if (flush_clear) begin
        meta[flush_set][flush_way].valid <= 1'b0;
        meta[flush_set][flush_way].dirty <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      req_write_q <= bus.req_write;
      req_tag_q   <= bus.req_addr[TAG_LSB +: TAG_WIDTH];
      req_idx_q   <= bus.req_addr[INDEX_LSB +: INDEX_WIDTH];
      req_woff_q  <= bus.req_addr[BYTE_OFF_WIDTH +: WORD_OFF_WIDTH];
      req_wdata_q <= bus.req_wdata;
    end
    if (store_hit) data_mem[req_idx_q][hit_way][int'(req_woff_q)*DATA_WIDTH +: DATA_WIDTH] <= req_wdata_q;
    if (install)   data_mem[req_idx_q][victim_q] <= refill_block;
  end

  cache_lru_tracker #(
    .NUM_WAYS (NUM_WAYS),
    .NUM_SETS (NUM_SETS)
  ) u_lru (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_set (req_idx_q),
    .lru_way    (lru_way),
    .upd_en     (lru_upd),
    .upd_set    (req_idx_q),
    .upd_way    (lru_upd_way)
  );

endmodule

// File: tb/tb_param_cache_bank.sv
// Directed bench for param_cache_bank (4 ways, 4 sets, 4-word blocks).
module tb_param_cache_bank;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  int          wb_cnt, rd_cnt, mem_ops;
  logic        first_op_write;
  logic [31:0] rd_addr_last;
  logic [31:0] wb_addrs[$];
  logic [31:0] wb_word0s[$];

  always #5 clk = ~clk;

  param_cache_bank_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .WORDS_PER_BLOCK(4)) bus ();

  param_cache_bank #(
    .NUM_WAYS(4), .NUM_SETS(4), .WORDS_PER_BLOCK(4),
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .PROC_ID_WIDTH(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic clear_log();
    wb_cnt = 0; rd_cnt = 0; mem_ops = 0; first_op_write = 1'b0; rd_addr_last = '0;
    wb_addrs.delete(); wb_word0s.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = 0; bus.flush_req = 0; bus.mem_req_ready = 0; bus.mem_resp_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns at the negedge of the cycle right after acceptance (LOOKUP).
  task automatic start_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    int cyc = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr; bus.req_wdata = wd;
    while (bus.req_ready !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    if (cyc >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: addr %h never accepted", addr);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Acts as an always-ready lower level until the response pulse is seen.
  task automatic run_to_resp(input logic [127:0] fill, output logic hit,
                             output logic [31:0] rd, output int lat);
    bit done = 0;
    lat = 1; hit = 1'bx; rd = 'x;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      if (bus.resp_valid === 1'b1) begin
        hit = bus.resp_hit; rd = bus.resp_rdata; done = 1;
      end else begin
        if (bus.mem_req_valid === 1'b1) begin
          bus.mem_req_ready = 1'b1;
          if (mem_ops == 0) first_op_write = bus.mem_req_write;
          mem_ops++;
          if (bus.mem_req_write === 1'b1) begin
            wb_cnt++; wb_addrs.push_back(bus.mem_req_addr); wb_word0s.push_back(bus.mem_wdata[31:0]);
          end else begin
            rd_cnt++; rd_addr_last = bus.mem_req_addr;
            bus.mem_resp_valid = 1'b1; bus.mem_rdata = fill;
          end
        end
        @(negedge clk);
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
        lat++;
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL resp_timeout: no response within 100 cycles");
    end
  endtask

  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [127:0] fill, output logic hit, output logic [31:0] rd,
                        output int lat);
    start_req(wr, addr, wd);
    run_to_resp(fill, hit, rd, lat);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.req_ready !== 1'b1)     begin n_bad++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 1'b0)    begin n_bad++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
    n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req_valid: got %b want 0", bus.mem_req_valid); end
    n_cmp++; if (bus.flush_done !== 1'b0)    begin n_bad++; $display("FAIL rst_flush_done: got %b want 0", bus.flush_done); end
    n_cmp++; if (bus.resp_rdata !== 32'h0)   begin n_bad++; $display("FAIL rst_resp_rdata: got %h want 0", bus.resp_rdata); end
    n_cmp++; if (bus.mem_req_addr !== 32'h0) begin n_bad++; $display("FAIL rst_mem_req_addr: got %h want 0", bus.mem_req_addr); end
  endtask

  task automatic test_miss_then_hit();
    logic hit; logic [31:0] rd; int lat;
    do_reset(); clear_log();
    access(1'b0, 32'h0000_0040, '0, {32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0}, hit, rd, lat);
    n_cmp++; if (hit !== 1'b0)         begin n_bad++; $display("FAIL t1_miss_hit: got %b want 0", hit); end
    n_cmp++; if (rd !== 32'h0)         begin n_bad++; $display("FAIL t1_miss_data: got %h want 0", rd); end
    n_cmp++; if (wb_cnt !== 0)         begin n_bad++; $display("FAIL t1_no_wb: got %0d want 0", wb_cnt); end
    n_cmp++; if (rd_addr_last !== 32'h0000_0040) begin n_bad++; $display("FAIL t1_refill_addr: got %h want 00000040", rd_addr_last); end
    n_cmp++; if (lat < 3)              begin n_bad++; $display("FAIL t1_miss_latency: got %0d want >=3", lat); end
    access(1'b0, 32'h0000_0044, '0, '0, hit, rd, lat);
    n_cmp++; if (hit !== 1'b1)         begin n_bad++; $display("FAIL t1_hit: got %b want 1", hit); end
    n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL t1_hit_data: got %h want deadbeef", rd); end
    n_cmp++; if (lat !== 1)            begin n_bad++; $display("FAIL t1_hit_latency: got %0d want 1", lat); end
  endtask

  task automatic test_dirty_eviction();
    logic hit; logic [31:0] rd; int lat;
    do_reset(); clear_log();
    access(1'b1, 32'h0000_0000, 32'h1111_1111, '0, hit, rd, lat);
    n_cmp++; if (rd !== 32'h1111_1111) begin n_bad++; $display("FAIL t2_store_merge: got %h want 11111111", rd); end
    access(1'b0, 32'h0000_0040, '0, '0, hit, rd, lat);
    access(1'b0, 32'h0000_0080, '0, '0, hit, rd, lat);
    access(1'b0, 32'h0000_00C0, '0, '0, hit, rd, lat);
    clear_log();
    access(1'b0, 32'h0000_0100, '0, {32'h0, 32'h0, 32'h0, 32'h5555_0100}, hit, rd, lat);
    n_cmp++; if (hit !== 1'b0)    begin n_bad++; $display("FAIL t2_evict_hit: got %b want 0", hit); end
    n_cmp++; if (wb_cnt !== 1)    begin n_bad++; $display("FAIL t2_wb_count: got %0d want 1", wb_cnt); end
    n_cmp++; if (first_op_write !== 1'b1) begin n_bad++; $display("FAIL t2_wb_first: got %b want 1", first_op_write); end
    n_cmp++; if ((wb_addrs.size() > 0 ? wb_addrs[0] : 32'hFFFF_FFFF) !== 32'h0)
      begin n_bad++; $display("FAIL t2_wb_addr: want 00000000"); end
    n_cmp++; if ((wb_word0s.size() > 0 ? wb_word0s[0] : 32'h0) !== 32'h1111_1111)
      begin n_bad++; $display("FAIL t2_wb_word0: want 11111111"); end
    n_cmp++; if (rd_addr_last !== 32'h0000_0100) begin n_bad++; $display("FAIL t2_refill_addr: got %h want 00000100", rd_addr_last); end
    n_cmp++; if (rd !== 32'h5555_0100) begin n_bad++; $display("FAIL t2_evict_data: got %h want 55550100", rd); end
  endtask

  task automatic test_lru_order();
    logic hit; logic [31:0] rd; int lat;
    do_reset(); clear_log();
    access(1'b0, 32'h0000_0000, '0, '0, hit, rd, lat);
    access(1'b0, 32'h0000_0040, '0, '0, hit, rd, lat);
    access(1'b0, 32'h0000_0080, '0, '0, hit, rd, lat);
    access(1'b0, 32'h0000_00C0, '0, '0, hit, rd, lat);
    access(1'b0, 32'h0000_0000, '0, '0, hit, rd, lat);
    n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL t3_retouch_hit: got %b want 1", hit); end
    clear_log();
    access(1'b0, 32'h0000_0100, '0, '0, hit, rd, lat);
    n_cmp++; if (wb_cnt !== 0) begin n_bad++; $display("FAIL t3_clean_no_wb: got %0d want 0", wb_cnt); end
    access(1'b0, 32'h0000_0000, '0, '0, hit, rd, lat);
    n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL t3_kept_000: got %b want 1", hit); end
    access(1'b0, 32'h0000_0040, '0, '0, hit, rd, lat);
    n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL t3_evicted_040: got %b want 0", hit); end
  endtask

  task automatic test_flush();
    logic hit; logic [31:0] rd; int lat;
    int done_cnt = 0, resp_cnt = 0, rd_req_cnt = 0;
    do_reset(); clear_log();
    access(1'b1, 32'h0000_0000, 32'hAAAA_0000, '0, hit, rd, lat);
    access(1'b1, 32'h0000_0010, 32'hBBBB_0010, '0, hit, rd, lat);
    clear_log();
    @(negedge clk);
    bus.flush_req = 1'b1; bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0;
    @(negedge clk);
    bus.flush_req = 1'b0; bus.req_valid = 1'b0;
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL t4_busy: got %b want 0", bus.req_ready); end
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (bus.flush_done === 1'b1) done_cnt++;
      if (bus.resp_valid === 1'b1) resp_cnt++;
      if (bus.mem_req_valid === 1'b1) begin
        bus.mem_req_ready = 1'b1;
        if (bus.mem_req_write === 1'b1) begin
          wb_cnt++; wb_addrs.push_back(bus.mem_req_addr); wb_word0s.push_back(bus.mem_wdata[31:0]);
        end else rd_req_cnt++;
      end
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
    end
    n_cmp++; if (wb_cnt !== 2)     begin n_bad++; $display("FAIL t4_wb_count: got %0d want 2", wb_cnt); end
    n_cmp++; if (rd_req_cnt !== 0) begin n_bad++; $display("FAIL t4_no_reads: got %0d want 0", rd_req_cnt); end
    n_cmp++; if (done_cnt !== 1)   begin n_bad++; $display("FAIL t4_done_pulse: got %0d want 1", done_cnt); end
    n_cmp++; if (resp_cnt !== 0)   begin n_bad++; $display("FAIL t4_req_not_taken: got %0d resp want 0", resp_cnt); end
    n_cmp++; if ((wb_addrs.size() > 1 ? wb_addrs[1] : 32'hFFFF_FFFF) !== 32'h0000_0010)
      begin n_bad++; $display("FAIL t4_wb_order: second write-back addr want 00000010"); end
    n_cmp++; if ((wb_word0s.size() > 0 ? wb_word0s[0] : 32'h0) !== 32'hAAAA_0000)
      begin n_bad++; $display("FAIL t4_wb_data: first write-back word0 want aaaa0000"); end
    access(1'b0, 32'h0000_0000, '0, '0, hit, rd, lat);
    n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL t4_line0_miss: got %b want 0", hit); end
    access(1'b0, 32'h0000_0010, '0, '0, hit, rd, lat);
    n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL t4_line1_miss: got %b want 0", hit); end
  endtask

  task automatic test_wb_backpressure();
    logic hit; logic [31:0] rd; int lat; int cyc = 0;
    logic a_write; logic [31:0] a0; logic [127:0] d0;
    bit stable_ok = 1, ready_ok = 1;
    do_reset(); clear_log();
    access(1'b1, 32'h0000_0000, 32'h1111_1111, '0, hit, rd, lat);
    access(1'b0, 32'h0000_0040, '0, '0, hit, rd, lat);
    access(1'b0, 32'h0000_0080, '0, '0, hit, rd, lat);
    access(1'b0, 32'h0000_00C0, '0, '0, hit, rd, lat);
    clear_log();
    start_req(1'b0, 32'h0000_0100, '0);
    while (bus.mem_req_valid !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
    a_write = bus.mem_req_write; a0 = bus.mem_req_addr; d0 = bus.mem_wdata;
    for (int i = 0; i < 10; i++) begin
      if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== a0 || bus.mem_wdata !== d0) stable_ok = 0;
      if (bus.req_ready !== 1'b0) ready_ok = 0;
      @(negedge clk);
    end
    n_cmp++; if (a_write !== 1'b1)       begin n_bad++; $display("FAIL t5_is_write: got %b want 1", a_write); end
    n_cmp++; if (a0 !== 32'h0)           begin n_bad++; $display("FAIL t5_wb_addr: got %h want 00000000", a0); end
    n_cmp++; if (d0[31:0] !== 32'h1111_1111) begin n_bad++; $display("FAIL t5_wb_word0: got %h want 11111111", d0[31:0]); end
    n_cmp++; if (!stable_ok)             begin n_bad++; $display("FAIL t5_stable: got unstable want stable"); end
    n_cmp++; if (!ready_ok)              begin n_bad++; $display("FAIL t5_req_ready: got 1 want 0"); end
    run_to_resp({32'h0, 32'h0, 32'h0, 32'h7777_0100}, hit, rd, lat);
    n_cmp++; if (wb_cnt !== 1)           begin n_bad++; $display("FAIL t5_wb_count: got %0d want 1", wb_cnt); end
    n_cmp++; if (hit !== 1'b0)           begin n_bad++; $display("FAIL t5_hit: got %b want 0", hit); end
    n_cmp++; if (rd !== 32'h7777_0100)   begin n_bad++; $display("FAIL t5_data: got %h want 77770100", rd); end
  endtask

  task automatic test_reset_in_refill();
    logic hit; logic [31:0] rd; int lat;
    do_reset(); clear_log();
    start_req(1'b0, 32'h0000_0040, '0);
    @(negedge clk);
    n_cmp++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_write !== 1'b0)
      begin n_bad++; $display("FAIL t6_in_refill: got valid %b write %b want 1 0", bus.mem_req_valid, bus.mem_req_write); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL t6_mem_drop: got %b want 0", bus.mem_req_valid); end
    n_cmp++; if (bus.req_ready !== 1'b1)     begin n_bad++; $display("FAIL t6_ready: got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 1'b0)    begin n_bad++; $display("FAIL t6_no_resp: got %b want 0", bus.resp_valid); end
    access(1'b0, 32'h0000_0040, '0, '0, hit, rd, lat);
    n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL t6_miss: got %b want 0", hit); end
  endtask

  initial begin
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.flush_req = 0; bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_rdata = '0;
    test_reset();
    test_miss_then_hit();
    test_dirty_eviction();
    test_lru_order();
    test_flush();
    test_wb_backpressure();
    test_reset_in_refill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
